// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
package mul_arb_pkg;

    localparam int DATA_W  = 16;
    localparam int MAX_REQ = 8;

    typedef enum logic {
        MUL = 1'b0,
        MLA = 1'b1
    } op_sel_e;

    // Lowest offset from ptr wins; the loop runs downward so the nearest hit is written last.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input logic [3:0]         num_req
    );
        logic [3:0] idx;
        rr_pick = ptr;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if ((4'(k) < num_req) && valid[idx[2:0]]) begin
                rr_pick = idx[2:0];
            end
        end
    endfunction

endpackage

// File: rtl/alu_mul.sv
// Combinational 16x16 signed multiplier returning the low 16 bits of the product.
module alu_mul
    import mul_arb_pkg::*;
(
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic        [DATA_W-1:0] p
);

    assign p = DATA_W'(a * b);

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one signed multiplier between NUM_REQ requesters,
// with an operand stage (S1) and a result stage (S2) carrying MUL/MLA results and N/Z flags.
module mul_share_arb
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [DATA_W*NUM_REQ-1:0] req_op1,
    input  logic [DATA_W*NUM_REQ-1:0] req_op2,
    input  logic [DATA_W*NUM_REQ-1:0] req_op3,
    input  logic [NUM_REQ-1:0]        req_acc,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_n,
    output logic                      rsp_z,
    output logic                      busy
);

    logic                 s1_valid;
    logic                 s2_valid;
    logic                 s1_en;
    logic                 s2_en;
    logic                 any_valid;
    logic                 accept;
    logic [MAX_REQ-1:0]   valid_pad;
    logic [IDW-1:0]       grant;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       ptr_next;
    logic [DATA_W-1:0]    g_op1;
    logic [DATA_W-1:0]    g_op2;
    logic [DATA_W-1:0]    g_op3;
    logic [DATA_W-1:0]    s1_a;
    logic [DATA_W-1:0]    s1_b;
    logic [DATA_W-1:0]    s1_c;
    op_sel_e              s1_op;
    logic [IDW-1:0]       s1_id;
    logic [DATA_W-1:0]    prod;
    logic [DATA_W-1:0]    sum;

    assign s2_en     = !s2_valid || rsp_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign any_valid = |req_valid;
    assign accept    = any_valid && s1_en;

    always_comb begin
        valid_pad                = '0;
        valid_pad[NUM_REQ-1:0]   = req_valid;
    end

    assign grant    = IDW'(rr_pick(valid_pad, 3'(rr_ptr), 4'(NUM_REQ)));
    assign ptr_next = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    assign g_op1 = req_op1[DATA_W*grant +: DATA_W];
    assign g_op2 = req_op2[DATA_W*grant +: DATA_W];
    assign g_op3 = req_op3[DATA_W*grant +: DATA_W];

    // Ready is held low during reset so outputs read zero the moment rst rises.
    always_comb begin
        req_ready = '0;
        if (any_valid && !rst) begin
            req_ready[grant] = s1_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_op    <= MUL;
            s1_id    <= '0;
            rr_ptr   <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= accept;
            end
            if (accept) begin
                s1_a   <= g_op1;
                s1_b   <= g_op2;
                s1_c   <= g_op3;
                s1_op  <= op_sel_e'(req_acc[grant]);
                s1_id  <= grant;
                rr_ptr <= ptr_next;
            end
        end
    end

    alu_mul u_alu_mul (
        .a (s1_a),
        .b (s1_b),
        .p (prod)
    );

    assign sum = prod + ((s1_op == MLA) ? s1_c : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_n      <= 1'b0;
            rsp_z      <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            rsp_id   <= s1_id;
            if (s1_valid) begin
                rsp_result <= sum;
                rsp_n      <= sum[DATA_W-1];
                rsp_z      <= (sum == '0);
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb: accepted requests push hand-computed results,
// a response monitor pops and compares them at each result handshake.
module tb_mul_share_arb;

    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic        acc;
        logic [15:0] exp;
    } vec_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    exp;
        logic [31:0]    cyc;
        logic           lat;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_op1;
    logic [16*NUM_REQ-1:0] req_op2;
    logic [16*NUM_REQ-1:0] req_op3;
    logic [NUM_REQ-1:0]    req_acc;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [15:0]           rsp_result;
    logic                  rsp_n;
    logic                  rsp_z;
    logic                  busy;

    vec_t        pend[NUM_REQ][$];
    exp_t        sb[$];
    int          grant_log[$];
    int          grant_cyc[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cyc      = 0;
    logic        lat_check = 1'b0;
    int          expg[8];
    logic [48:0] prev_d[NUM_REQ];
    logic [NUM_REQ-1:0] prev_wait;

    mul_share_arb #(.NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_op3    (req_op3),
        .req_acc    (req_acc),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_n      (rsp_n),
        .rsp_z      (rsp_z),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic acc, input logic [15:0] exp);
        vec_t v;
        v = '{a: a, b: b, c: c, acc: acc, exp: exp};
        pend[r].push_back(v);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic bit all_pend_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((!all_pend_empty() || sb.size() != 0) && n < 200) begin
            waitCycles(1);
            n++;
        end
        checkOutput({"drain_", name}, 32'(n < 200), 1);
    endtask

    task automatic checkGrants(input string name, input int n);
        checkOutput({name, "_count"}, grant_log.size(), n);
        for (int k = 0; k < n && k < grant_log.size(); k++) begin
            checkOutput($sformatf("%s_grant%0d", name, k), grant_log[k], expg[k]);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"},  32'(req_ready),  0);
        checkOutput({tag, "_rsp_valid"},  32'(rsp_valid),  0);
        checkOutput({tag, "_rsp_id"},     32'(rsp_id),     0);
        checkOutput({tag, "_rsp_result"}, 32'(rsp_result), 0);
        checkOutput({tag, "_rsp_n"},      32'(rsp_n),      0);
        checkOutput({tag, "_rsp_z"},      32'(rsp_z),      0);
        checkOutput({tag, "_busy"},       32'(busy),       0);
    endtask

    // Requester model: present the head of each queue until it is accepted.
    initial begin
        vec_t dv;
        req_valid = '0;
        req_op1   = '0;
        req_op2   = '0;
        req_op3   = '0;
        req_acc   = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!rst && pend[i].size() > 0) begin
                    dv = pend[i][0];
                    req_valid[i]        = 1'b1;
                    req_op1[16*i +: 16] = dv.a;
                    req_op2[16*i +: 16] = dv.b;
                    req_op3[16*i +: 16] = dv.c;
                    req_acc[i]          = dv.acc;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Accept monitor: one sample just before each rising edge.
    initial begin
        vec_t av;
        exp_t ev;
        prev_wait = '0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prev_wait = '0;
            end else begin
                checkOutput("ready_onehot", 32'($countones(req_ready) <= 1), 1);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (prev_wait[i]) begin
                        assert (req_valid[i] && {req_acc[i], req_op1[16*i +: 16], req_op2[16*i +: 16],
                                req_op3[16*i +: 16]} == prev_d[i])
                        else $error("[TB] requester %0d changed a pending request", i);
                    end
                    prev_wait[i] = req_valid[i] & ~req_ready[i];
                    prev_d[i]    = {req_acc[i], req_op1[16*i +: 16], req_op2[16*i +: 16], req_op3[16*i +: 16]};
                    if (req_valid[i] && req_ready[i] && pend[i].size() > 0) begin
                        av = pend[i].pop_front();
                        ev = '{id: IDW'(i), exp: av.exp, cyc: cyc, lat: lat_check};
                        sb.push_back(ev);
                        grant_log.push_back(i);
                        grant_cyc.push_back(int'(cyc));
                    end
                end
            end
        end
    end

    // Response monitor: compare every result handshake against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_id",     32'(rsp_id),     32'(e.id));
                    checkOutput("rsp_result", 32'(rsp_result), 32'(e.exp));
                    checkOutput("rsp_n",      32'(rsp_n),      32'(e.exp[15]));
                    checkOutput("rsp_z",      32'(rsp_z),      32'(e.exp == 16'h0000));
                    if (e.lat) begin
                        checkOutput("rsp_latency", cyc - e.cyc, 2);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        waitCycles(2);
        checkResetOutputs("init");
        rst = 1'b0;
        waitCycles(1);

        // Single MUL: 3 * -4
        lat_check = 1'b1;
        applyStimulus(0, 16'd3, 16'hFFFC, 16'd0, 1'b0, 16'hFFF4);
        waitDrain("mul");

        // MLA wrap, ignored op3 on MUL, zero result; pointer starts at 1
        grant_log.delete(); grant_cyc.delete();
        applyStimulus(1, 16'h7FFF, 16'h0002, 16'h0003, 1'b1, 16'h0001);
        applyStimulus(2, 16'h0100, 16'h0100, 16'h0005, 1'b1, 16'h0005);
        applyStimulus(3, 16'hFFFF, 16'h0007, 16'h0064, 1'b0, 16'hFFF9);
        applyStimulus(3, 16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h0000);
        waitDrain("mla");
        expg = '{1, 2, 3, 3, 0, 0, 0, 0};
        checkGrants("mla", 4);

        // Round robin with all four requesters valid
        grant_log.delete(); grant_cyc.delete();
        applyStimulus(0, 16'd2,    16'd3,    16'd0,    1'b0, 16'h0006);
        applyStimulus(0, 16'hFFFE, 16'hFFFE, 16'd0,    1'b0, 16'h0004);
        applyStimulus(1, 16'd5,    16'hFFFF, 16'd0,    1'b0, 16'hFFFB);
        applyStimulus(1, 16'h4000, 16'd4,    16'd0,    1'b0, 16'h0000);
        applyStimulus(2, 16'h0010, 16'h0010, 16'd0,    1'b0, 16'h0100);
        applyStimulus(2, 16'd10,   16'd10,   16'hFF9C, 1'b1, 16'h0000);
        applyStimulus(3, 16'd4,    16'd4,    16'd1,    1'b1, 16'h0011);
        applyStimulus(3, 16'h1234, 16'd1,    16'd0,    1'b0, 16'h1234);
        waitDrain("rr");
        expg = '{0, 1, 2, 3, 0, 1, 2, 3};
        checkGrants("rr", 8);
        for (int k = 1; k < grant_cyc.size(); k++) begin
            checkOutput($sformatf("rr_gap%0d", k), grant_cyc[k] - grant_cyc[k-1], 1);
        end

        // Backpressure: stream from req1 with the consumer stalled
        lat_check = 1'b0;
        rsp_ready = 1'b0;
        applyStimulus(1, 16'd1,    16'd1, 16'd0, 1'b0, 16'h0001);
        applyStimulus(1, 16'd2,    16'd2, 16'd0, 1'b0, 16'h0004);
        applyStimulus(1, 16'd3,    16'd3, 16'd0, 1'b0, 16'h0009);
        applyStimulus(1, 16'hFFFD, 16'd3, 16'd0, 1'b0, 16'hFFF7);
        waitCycles(4);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_rsp_valid",  32'(rsp_valid),  1);
            checkOutput("bp_rsp_result", 32'(rsp_result), 32'h0001);
            checkOutput("bp_rsp_id",     32'(rsp_id),     1);
            checkOutput("bp_req_ready",  32'(req_ready),  0);
            waitCycles(1);
        end
        rsp_ready = 1'b1;
        waitDrain("bp");

        // Pointer hold: req3 waits under stall, req0 joins later
        grant_log.delete(); grant_cyc.delete();
        rsp_ready = 1'b0;
        applyStimulus(1, 16'h0007, 16'h0003, 16'd0, 1'b0, 16'h0015);
        applyStimulus(1, 16'h0100, 16'h00FF, 16'd0, 1'b0, 16'hFF00);
        waitCycles(4);
        applyStimulus(3, 16'hFFFF, 16'hFFFF, 16'h7FFF, 1'b1, 16'h8000);
        waitCycles(3);
        checkOutput("hold_req_ready",  32'(req_ready),  0);
        checkOutput("hold_rsp_result", 32'(rsp_result), 32'h0015);
        applyStimulus(0, 16'h8000, 16'hFFFF, 16'd0, 1'b0, 16'h8000);
        waitCycles(2);
        checkOutput("hold_req_ready2", 32'(req_ready), 0);
        rsp_ready = 1'b1;
        waitDrain("hold");
        expg = '{1, 1, 3, 0, 0, 0, 0, 0};
        checkGrants("hold", 4);

        // Reset with both stages full; the pointer sits at 1 beforehand
        rsp_ready = 1'b0;
        applyStimulus(0, 16'd1, 16'd1, 16'd0, 1'b0, 16'h0001);
        applyStimulus(0, 16'd2, 16'd1, 16'd0, 1'b0, 16'h0002);
        applyStimulus(0, 16'd3, 16'd1, 16'd0, 1'b0, 16'h0003);
        waitCycles(4);
        checkOutput("pre_reset_busy", 32'(busy), 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("midflight");
        for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
        sb.delete();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        grant_log.delete(); grant_cyc.delete();
        rsp_ready = 1'b1;
        lat_check = 1'b1;
        #1;
        applyStimulus(1, 16'd0, 16'd5, 16'hFFFF, 1'b1, 16'hFFFF);
        applyStimulus(0, 16'd3, 16'd5, 16'd0,    1'b0, 16'h000F);
        waitDrain("post_reset");
        expg = '{0, 1, 0, 0, 0, 0, 0, 0};
        checkGrants("post_reset", 2);
        waitCycles(4);
        checkOutput("post_reset_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
